// File: rtl/seq_pkg.sv
// Shared types and defaults for the multi-track step sequencer.
package seq_pkg;

    localparam int unsigned SEQ_NOTE_W        = 4;
    localparam int unsigned MIN_TICKS_DEFAULT = 4;

    typedef logic [SEQ_NOTE_W-1:0] note_t;

    localparam note_t NOTE_REST = '0;

    typedef enum logic {SEQ_STOP, SEQ_RUN} seq_state_e;

endpackage

// File: rtl/seq_track_engine_if.sv
// Control/status bundle between a sequencer host and seq_track_engine.
// swing_ticks exists only when SEQ_SWING_EN is defined.
interface seq_track_engine_if #(
    parameter int unsigned NUM_STEPS  = 16,
    parameter int unsigned NUM_TRACKS = 4,
    parameter int unsigned NOTE_W     = 4,
    parameter int unsigned TEMPO_W    = 24
);
    localparam int unsigned IDX_W = $clog2(NUM_STEPS);

    logic                                  run;
    logic [TEMPO_W-1:0]                    tempo_ticks;
    logic [NUM_TRACKS*NUM_STEPS*NOTE_W-1:0] pattern;
    logic [NUM_TRACKS-1:0]                 track_mute;
`ifdef SEQ_SWING_EN
    logic [TEMPO_W-2:0]                    swing_ticks;
`endif
    logic [IDX_W-1:0]                      step_idx;
    logic                                  step_pulse;
    logic [NUM_TRACKS*NOTE_W-1:0]          track_pitch;
    logic [NUM_TRACKS-1:0]                 track_gate;
    logic                                  running;

`ifdef SEQ_SWING_EN
    modport master (
        output run, tempo_ticks, pattern, track_mute, swing_ticks,
        input  step_idx, step_pulse, track_pitch, track_gate, running
    );
    modport slave (
        input  run, tempo_ticks, pattern, track_mute, swing_ticks,
        output step_idx, step_pulse, track_pitch, track_gate, running
    );
`else
    modport master (
        output run, tempo_ticks, pattern, track_mute,
        input  step_idx, step_pulse, track_pitch, track_gate, running
    );
    modport slave (
        input  run, tempo_ticks, pattern, track_mute,
        output step_idx, step_pulse, track_pitch, track_gate, running
    );
`endif

endinterface

// File: rtl/seq_step_timer.sv
// Step tick counter: clamps/latches step length and gate length at each step start.
// With SEQ_SWING_EN, even steps are lengthened and odd steps shortened by the swing amount.
module seq_step_timer
    import seq_pkg::*;
#(
    parameter int unsigned TEMPO_W   = 24,
    parameter int unsigned MIN_TICKS = MIN_TICKS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               active,
    input  logic [TEMPO_W-1:0] tempo_ticks,
`ifdef SEQ_SWING_EN
    input  logic               next_odd,
    input  logic [TEMPO_W-2:0] swing_ticks,
`endif
    output logic               step_start,
    output logic               gate_active
);
    // One extra bit so base + swing cannot overflow.
    localparam int unsigned LEN_W = TEMPO_W + 1;

    logic [LEN_W-1:0] cnt_q, len_q, glen_q;
    logic [LEN_W-1:0] base_len, new_len, half_len, new_glen;

    always_comb begin
        base_len = (tempo_ticks < TEMPO_W'(MIN_TICKS)) ? LEN_W'(MIN_TICKS) : {1'b0, tempo_ticks};
`ifdef SEQ_SWING_EN
        begin
            logic [LEN_W-1:0] sw;
            sw = ({2'b00, swing_ticks} < (base_len >> 1)) ? {2'b00, swing_ticks} : (base_len >> 1);
            new_len = next_odd ? (base_len - sw) : (base_len + sw);
        end
`else
        new_len = base_len;
`endif
        half_len = new_len >> 1;
        new_glen = (half_len == '0) ? LEN_W'(1) : half_len;
    end

    assign step_start  = go | (active & (cnt_q == len_q - LEN_W'(1)));
    // High while the following cycle is still inside the gate window.
    assign gate_active = (cnt_q + LEN_W'(1)) < glen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            len_q  <= '0;
            glen_q <= '0;
        end else if (step_start) begin
            cnt_q  <= '0;
            len_q  <= new_len;
            glen_q <= new_glen;
        end else if (active) begin
            cnt_q  <= cnt_q + LEN_W'(1);
        end else begin
            cnt_q  <= '0;
        end
    end

endmodule

// File: rtl/seq_track_engine.sv
// Multi-track step sequencer core: run/stop FSM, step index, per-track pitch and gate.
// Optional swing timing is enabled by defining SEQ_SWING_EN.
module seq_track_engine
    import seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS  = 16,
    parameter int unsigned NUM_TRACKS = 4,
    parameter int unsigned NOTE_W     = 4,
    parameter int unsigned TEMPO_W    = 24,
    parameter int unsigned MIN_TICKS  = MIN_TICKS_DEFAULT
) (
    input logic               clk,
    input logic               rst_n,
    seq_track_engine_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_STEPS);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    seq_state_e       state_q;
    logic [IDX_W-1:0] step_idx_q, next_idx;
    logic             pulse_q, running_q;
    logic             go, active, step_start, gate_active;

    // Asynchronous assertion, synchronous release of the internal reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign go       = (state_q == SEQ_STOP) && bus.run;
    assign active   = (state_q == SEQ_RUN) && bus.run;
    assign next_idx = go ? '0 : step_idx_q + IDX_W'(1);

    seq_step_timer #(
        .TEMPO_W   (TEMPO_W),
        .MIN_TICKS (MIN_TICKS)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_int_n),
        .go          (go),
        .active      (active),
        .tempo_ticks (bus.tempo_ticks),
`ifdef SEQ_SWING_EN
        .next_odd    (next_idx[0]),
        .swing_ticks (bus.swing_ticks),
`endif
        .step_start  (step_start),
        .gate_active (gate_active)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= SEQ_STOP;
            step_idx_q <= '0;
            pulse_q    <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            pulse_q <= step_start;
            unique case (state_q)
                SEQ_STOP: begin
                    if (bus.run) begin
                        state_q    <= SEQ_RUN;
                        running_q  <= 1'b1;
                        step_idx_q <= '0;
                    end
                end
                SEQ_RUN: begin
                    if (!bus.run) begin
                        state_q    <= SEQ_STOP;
                        running_q  <= 1'b0;
                        step_idx_q <= '0;
                    end else if (step_start) begin
                        step_idx_q <= next_idx;
                    end
                end
                default: state_q <= SEQ_STOP;
            endcase
        end
    end

    assign bus.step_idx   = step_idx_q;
    assign bus.step_pulse = pulse_q;
    assign bus.running    = running_q;

    for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
        logic [NOTE_W-1:0] lane [NUM_STEPS];
        logic [NOTE_W-1:0] note, pitch_q;
        logic              gate_q;

        for (genvar s = 0; s < NUM_STEPS; s++) begin : g_step
            assign lane[s] = bus.pattern[(t*NUM_STEPS+s)*NOTE_W +: NOTE_W];
        end
        assign note = lane[next_idx];

        always_ff @(posedge clk or negedge rst_int_n) begin
            if (!rst_int_n) begin
                pitch_q <= '0;
                gate_q  <= 1'b0;
            end else if (state_q == SEQ_RUN && !bus.run) begin
                gate_q  <= 1'b0;
            end else if (step_start) begin
                pitch_q <= note;
                gate_q  <= (note != NOTE_W'(NOTE_REST)) && !bus.track_mute[t];
            end else begin
                // Mute can only drop the gate mid-step; it never re-raises it.
                gate_q  <= gate_q && !bus.track_mute[t] && gate_active;
            end
        end

        assign bus.track_pitch[t*NOTE_W +: NOTE_W] = pitch_q;
        assign bus.track_gate[t]                   = gate_q;
    end

endmodule

// File: tb/tb_seq_track_engine.sv
// Randomised bench for seq_track_engine against a cycle-level behavioural model.
module tb_seq_track_engine;
    localparam int NS = 4;
    localparam int NT = 2;
    localparam int NW = 4;
    localparam int TW = 8;
    localparam int MT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_track_engine_if #(
        .NUM_STEPS  (NS),
        .NUM_TRACKS (NT),
        .NOTE_W     (NW),
        .TEMPO_W    (TW)
    ) bus ();

    seq_track_engine #(
        .NUM_STEPS  (NS),
        .NUM_TRACKS (NT),
        .NOTE_W     (NW),
        .TEMPO_W    (TW),
        .MIN_TICKS  (MT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: what the outputs should show after the latest edge.
    int m_sync, m_step, m_pos, m_len, m_glen;
    bit m_run, m_pulse;
    int m_pitch [NT];
    bit m_gate  [NT];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int note_of(input int t, input int s);
        return int'(bus.pattern[(t*NS+s)*NW +: NW]);
    endfunction

    task automatic model_reset();
        m_sync = 0; m_step = 0; m_pos = 0; m_len = 0; m_glen = 0;
        m_run = 0; m_pulse = 0;
        for (int t = 0; t < NT; t++) begin
            m_pitch[t] = 0;
            m_gate[t]  = 0;
        end
    endtask

    task automatic model_start(input int s);
        int base, sw;
        base = (int'(bus.tempo_ticks) < MT) ? MT : int'(bus.tempo_ticks);
        sw = 0;
`ifdef SEQ_SWING_EN
        sw = (int'(bus.swing_ticks) < base / 2) ? int'(bus.swing_ticks) : base / 2;
`endif
        m_len   = (s % 2 == 0) ? base + sw : base - sw;
        m_glen  = (m_len / 2 < 1) ? 1 : m_len / 2;
        m_run   = 1; m_step = s; m_pos = 0; m_pulse = 1;
        for (int t = 0; t < NT; t++) begin
            m_pitch[t] = note_of(t, s);
            m_gate[t]  = (m_pitch[t] != 0) && !bus.track_mute[t];
        end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        if (m_sync < 2) begin
            m_sync++;
            return;
        end
        if (!m_run) begin
            if (bus.run) model_start(0);
            else m_pulse = 0;
        end else if (!bus.run) begin
            m_run = 0; m_step = 0; m_pos = 0; m_pulse = 0;
            for (int t = 0; t < NT; t++) m_gate[t] = 0;
        end else if (m_pos == m_len - 1) begin
            model_start((m_step + 1) % NS);
        end else begin
            m_pos++;
            m_pulse = 0;
            for (int t = 0; t < NT; t++)
                m_gate[t] = m_gate[t] && !bus.track_mute[t] && (m_pos < m_glen);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] p, g;
        p = '0; g = '0;
        for (int t = 0; t < NT; t++) begin
            p = p | (32'(m_pitch[t]) << (t * NW));
            g[t] = m_gate[t];
        end
        check_eq("step_idx",    32'(bus.step_idx),    32'(m_step));
        check_eq("step_pulse",  32'(bus.step_pulse),  32'(m_pulse));
        check_eq("running",     32'(bus.running),     32'(m_run));
        check_eq("track_pitch", 32'(bus.track_pitch), p);
        check_eq("track_gate",  32'(bus.track_gate),  g);
    endtask

    // Advance one clock; inputs are changed by the caller on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1 check_outputs();
        @(negedge clk);
    endtask

    task automatic assert_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
    endtask

    task automatic set_lane(input int t, input int n0, input int n1, input int n2, input int n3);
        bus.pattern[(t*NS+0)*NW +: NW] = NW'(n0);
        bus.pattern[(t*NS+1)*NW +: NW] = NW'(n1);
        bus.pattern[(t*NS+2)*NW +: NW] = NW'(n2);
        bus.pattern[(t*NS+3)*NW +: NW] = NW'(n3);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.run = 1'b0;
        bus.tempo_ticks = TW'(10);
        bus.pattern = '0;
        bus.track_mute = '0;
`ifdef SEQ_SWING_EN
        bus.swing_ticks = (TW-1)'(3);
`endif
        set_lane(0, 1, 2, 3, 4);
        set_lane(1, 0, 5, 0, 5);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();

        // Basic play at tempo 10, then clamp, then a mid-step tempo change.
        bus.run = 1'b1;
        repeat (45) tick();
        bus.tempo_ticks = TW'(2);
        repeat (20) tick();
        bus.tempo_ticks = TW'(10);
        repeat (7) tick();
        bus.tempo_ticks = TW'(20);
        repeat (45) tick();
        bus.tempo_ticks = TW'(10);
        repeat (13) tick();
        bus.track_mute[1] = 1'b1;
        repeat (5) tick();
        bus.track_mute[1] = 1'b0;
        repeat (20) tick();
        bus.run = 1'b0;
        repeat (5) tick();
        bus.run = 1'b1;
        repeat (14) tick();
        assert_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();

        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 15) bus.run = ~bus.run;
            else if (r < 60) bus.tempo_ticks = TW'($urandom_range(0, 14));
            else if (r < 140) bus.track_mute = NT'($urandom);
            else if (r < 220) bus.pattern[$urandom_range(0, NT*NS-1)*NW +: NW] = NW'($urandom);
`ifdef SEQ_SWING_EN
            else if (r < 250) bus.swing_ticks = (TW-1)'($urandom_range(0, 9));
`endif
            else if (r >= 995) begin
                assert_reset();
                repeat (int'($urandom_range(1, 3))) tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
